icache_fill: RTL and testbench

ICACHE_FILL -- requirements
Module: icache_fill

---
 rtl/icache_fill.sv | 133 +++++++++++++
 tb/tb_icache_fill.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
`default_nettype none
// ============================================================================
// icache_fill : direct-mapped one-word-line I-cache with byte-serial refill
// Rev 1.0
// ============================================================================
module icache_fill #(
  parameter int LINES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        done_o,
  output logic [31:0] inst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_req_pc;
  logic [2:0]       r_cnt;
  logic             r_cap;
  logic [1:0]       r_cap_k;
  logic [23:0]      r_word;
  logic             r_flushed;
  logic [31:0]      r_inst;
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_hit;
  logic          w_grant;
  logic          w_last;
  logic          w_wr;
  logic          w_pc_match;
  logic [31:0]   w_fill_word;

  assign w_idx       = r_req_pc[2 +: IW];
  assign w_tag       = r_req_pc[31 -: TW];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush_i;
  assign mem_req_o   = (r_state == S_FILL) && !r_cnt[2];
  assign mem_addr_o  = r_req_pc + {29'd0, r_cnt};
  assign w_grant     = mem_req_o && mem_grant_i;
  // r_cap marks that last cycle's granted byte is on mem_din_i now
  assign w_last      = (r_state == S_FILL) && r_cap && (r_cap_k == 2'd3);
  assign w_fill_word = {mem_din_i, r_word};
  assign w_wr        = rdy && w_last && !r_flushed && !flush_i;
  assign w_pc_match  = (pc_i[31:2] == r_req_pc[31:2]);
  assign done_o      = rdy && (r_state == S_DONE) && req_i && w_pc_match &&
                       !flush_i && !r_flushed;
  assign inst_o      = r_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_req_pc  <= '0;
      r_cnt     <= '0;
      r_cap     <= 1'b0;
      r_cap_k   <= '0;
      r_word    <= '0;
      r_flushed <= 1'b0;
      r_inst    <= '0;
      r_valid   <= '0;
    end else if (rdy) begin
      r_cap <= w_grant;
      if (w_grant) r_cap_k <= r_cnt[1:0];
      if (flush_i)   r_valid        <= '0;
      else if (w_wr) r_valid[w_idx] <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_req_pc  <= pc_i & 32'hFFFF_FFFC;
            r_flushed <= 1'b0;
            r_state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_inst  <= r_data[w_idx];
            r_state <= S_DONE;
          end else begin
            r_cnt   <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          // a flush lets the fill drain but poisons its result
          if (flush_i) r_flushed <= 1'b1;
          if (w_grant) r_cnt <= r_cnt + 3'd1;
          if (r_cap) begin
            case (r_cap_k)
              2'd0:    r_word[7:0]   <= mem_din_i;
              2'd1:    r_word[15:8]  <= mem_din_i;
              2'd2:    r_word[23:16] <= mem_din_i;
              default: ;
            endcase
          end
          if (w_last) begin
            r_inst  <= w_fill_word;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= w_fill_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill.sv
`default_nettype none
// ============================================================================
// tb_icache_fill : randomized self-checking bench for icache_fill
// Rev 1.0
// ============================================================================
module tb_icache_fill;

  localparam int LINES = 32;
  localparam int IW    = $clog2(LINES);

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        req_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        done_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_din_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [logic [31:0]];
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] q_addr [$];
  int          q_gt   [$];
  bit          pend;
  logic [7:0]  pend_data;

  icache_fill #(.LINES(LINES)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .req_i      (req_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .done_o     (done_o),
    .inst_o     (inst_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_grant_i(mem_grant_i),
    .mem_din_i  (mem_din_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] b;
    b = pc & 32'hFFFF_FFFC;
    return {mem_rd(b + 32'd3), mem_rd(b + 32'd2), mem_rd(b + 32'd1), mem_rd(b)};
  endfunction

  function automatic bit m_is_hit(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % LINES);
    return m_valid[idx] && (m_tag[idx] == (pc >> (2 + IW)));
  endfunction

  function automatic void m_fill(input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) % LINES);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = pc >> (2 + IW);
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // FILL starts 2 cycles after the request; done follows the 4th grant by 2
  function automatic int exp_miss_lat(input logic [31:0] g);
    int n;
    n = 0;
    for (int j = 0; j < 64; j++) begin
      if (j >= 32 || g[j]) begin
        n++;
        if (n == 4) return 2 + j + 2;
      end
    end
    return -1;
  endfunction

  function automatic bit addrs_ok(input logic [31:0] pc, input int n);
    logic [31:0] b;
    b = pc & 32'hFFFF_FFFC;
    if (q_addr.size() != n) return 1'b0;
    foreach (q_addr[k]) if (q_addr[k] !== b + 32'(k % 4)) return 1'b0;
    return 1'b1;
  endfunction

  // Drives one request from IDLE; entered and left at posedge+1.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] pc2, input int sw_t,
                           input int fl_t, input logic [31:0] gpat, input bit rdy_rand,
                           input int ncyc, input bit stop_on_done,
                           output int first_done, output int n_done,
                           output logic [31:0] inst_d, output logic [31:0] pc_d, output int n_req);
    first_done = -1; n_done = 0; n_req = 0; inst_d = '0; pc_d = '0;
    q_addr.delete(); q_gt.delete();
    for (int t = 0; t < ncyc; t++) begin
      req_i   = 1'b1;
      pc_i    = (sw_t >= 0 && t >= sw_t) ? pc2 : pc;
      flush_i = (t == fl_t);
      if (t >= 2 && t < 34) mem_grant_i = gpat[t - 2];
      else                  mem_grant_i = 1'b1;
      rdy       = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_din_i = pend ? pend_data : 8'($urandom);
      @(negedge clk);
      if (done_o) begin
        n_done++;
        if (first_done < 0) begin first_done = t; inst_d = inst_o; pc_d = pc_i; end
      end
      if (mem_req_o) n_req++;
      if (rdy && pend) pend = 1'b0;
      if (rdy && mem_req_o && mem_grant_i) begin
        q_addr.push_back(mem_addr_o);
        q_gt.push_back(t);
        pend      = 1'b1;
        pend_data = mem_rd(mem_addr_o);
      end
      @(posedge clk); #1;
      if (stop_on_done && first_done >= 0) break;
    end
    req_i = 1'b0; flush_i = 1'b0; rdy = 1'b1; mem_grant_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; req_i = 1'b0; pc_i = '0; flush_i = 1'b0;
    mem_grant_i = 1'b0; mem_din_i = '0; pend = 1'b0;
    m_flush();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_cmp++; if (inst_o !== 32'h0)     begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst_o); end
    n_cmp++; if (mem_req_o !== 1'b0)   begin n_bad++; $display("FAIL reset_memreq: got %b want 0", mem_req_o); end
    n_cmp++; if (mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr_o); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int fd, nd, nr; logic [31:0] ins, pcd; bit ok;
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    run_fetch(32'h100, 32'h100, -1, -1, '1, 1'b0, 60, 1'b1, fd, nd, ins, pcd, nr);
    n_cmp++; if (fd !== 7) begin n_bad++; $display("FAIL cold_lat: got %0d want 7", fd); end
    n_cmp++; if (ins !== 32'h0000_0513) begin n_bad++; $display("FAIL cold_inst: got %h want 00000513", ins); end
    ok = addrs_ok(32'h100, 4);
    if (ok) foreach (q_gt[k]) if (q_gt[k] != 2 + k) ok = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cold_addrs: got %0d grants want 4 consecutive from 100", q_addr.size()); end
    m_fill(32'h100);
  endtask

  task automatic test_hit();
    int fd, nd, nr; logic [31:0] ins, pcd;
    run_fetch(32'h100, 32'h100, -1, -1, '1, 1'b0, 60, 1'b1, fd, nd, ins, pcd, nr);
    n_cmp++; if (fd !== 2) begin n_bad++; $display("FAIL hit_lat: got %0d want 2", fd); end
    n_cmp++; if (ins !== 32'h0000_0513) begin n_bad++; $display("FAIL hit_inst: got %h want 00000513", ins); end
    n_cmp++; if (nr !== 0) begin n_bad++; $display("FAIL hit_memreq: got %0d cycles want 0", nr); end
  endtask

  task automatic test_conflict();
    int fd, nd, nr; logic [31:0] ins, pcd, pcs [2];
    pcs[0] = 32'h180; pcs[1] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      run_fetch(pcs[i], pcs[i], -1, -1, '1, 1'b0, 60, 1'b1, fd, nd, ins, pcd, nr);
      n_cmp++; if (fd !== 7) begin n_bad++; $display("FAIL conflict_lat[%0d]: got %0d want 7", i, fd); end
      n_cmp++; if (ins !== word_at(pcs[i])) begin n_bad++; $display("FAIL conflict_inst[%0d]: got %h want %h", i, ins, word_at(pcs[i])); end
      n_cmp++; if (!addrs_ok(pcs[i], 4)) begin n_bad++; $display("FAIL conflict_addrs[%0d]: got %0d grants want 4", i, q_addr.size()); end
      m_fill(pcs[i]);
    end
  endtask

  task automatic test_grant_gaps();
    int fd, nd, nr; logic [31:0] ins, pcd; bit ok;
    run_fetch(32'h340, 32'h340, -1, -1, 32'hFFFF_FFD9, 1'b0, 60, 1'b1, fd, nd, ins, pcd, nr);
    n_cmp++; if (fd !== 10) begin n_bad++; $display("FAIL gaps_lat: got %0d want 10", fd); end
    n_cmp++; if (ins !== word_at(32'h340)) begin n_bad++; $display("FAIL gaps_inst: got %h want %h", ins, word_at(32'h340)); end
    ok = addrs_ok(32'h340, 4);
    if (ok) ok = (q_gt[0] == 2) && (q_gt[1] == 5) && (q_gt[2] == 6) && (q_gt[3] == 8);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gaps_addrs: got %0d grants want 4 at cycles 2,5,6,8", q_addr.size()); end
    m_fill(32'h340);
  endtask

  task automatic test_flush_mid_fill();
    int fd, nd, nr; logic [31:0] ins, pcd;
    run_fetch(32'h400, 32'h400, -1, 4, '1, 1'b0, 8, 1'b0, fd, nd, ins, pcd, nr);
    m_flush();
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL flush_done: got %0d pulses want 0", nd); end
    n_cmp++; if (!addrs_ok(32'h400, 4)) begin n_bad++; $display("FAIL flush_drain: got %0d grants want 4", q_addr.size()); end
    run_fetch(32'h400, 32'h400, -1, -1, '1, 1'b0, 60, 1'b1, fd, nd, ins, pcd, nr);
    n_cmp++; if (fd !== 7) begin n_bad++; $display("FAIL flush_refetch_lat: got %0d want 7", fd); end
    m_fill(32'h400);
  endtask

  task automatic test_branch();
    int fd, nd, nr; logic [31:0] ins, pcd;
    run_fetch(32'h100, 32'h200, 3, -1, '1, 1'b0, 8, 1'b0, fd, nd, ins, pcd, nr);
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL branch_stale_done: got %0d pulses want 0", nd); end
    n_cmp++; if (!addrs_ok(32'h100, 4)) begin n_bad++; $display("FAIL branch_addrs: got %0d grants want 4 from 100", q_addr.size()); end
    m_fill(32'h100);
    run_fetch(32'h100, 32'h100, -1, -1, '1, 1'b0, 60, 1'b1, fd, nd, ins, pcd, nr);
    n_cmp++; if (fd !== 2) begin n_bad++; $display("FAIL branch_rehit_lat: got %0d want 2", fd); end
    n_cmp++; if (ins !== 32'h0000_0513) begin n_bad++; $display("FAIL branch_rehit_inst: got %h want 00000513", ins); end
  endtask

  task automatic test_rdy_stall();
    int fd, nd, nr; logic [31:0] ins, pcd;
    run_fetch(32'h600, 32'h600, -1, -1, '1, 1'b1, 300, 1'b1, fd, nd, ins, pcd, nr);
    n_cmp++; if (fd < 7) begin n_bad++; $display("FAIL stall_lat: got %0d want >=7", fd); end
    n_cmp++; if (ins !== word_at(32'h600)) begin n_bad++; $display("FAIL stall_inst: got %h want %h", ins, word_at(32'h600)); end
    n_cmp++; if (!addrs_ok(32'h600, 4)) begin n_bad++; $display("FAIL stall_addrs: got %0d grants want 4 in order", q_addr.size()); end
    m_fill(32'h600);
  endtask

  task automatic test_reset_mid_fill();
    int fd, nd, nr; logic [31:0] ins, pcd;
    run_fetch(32'h700, 32'h700, -1, -1, '1, 1'b0, 4, 1'b0, fd, nd, ins, pcd, nr);
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rstfill_memreq: got %b want 0", mem_req_o); end
    @(posedge clk); #1;
    rst = 1'b1; pend = 1'b0;
    m_flush();
    run_fetch(32'h700, 32'h700, -1, -1, '1, 1'b0, 60, 1'b1, fd, nd, ins, pcd, nr);
    n_cmp++; if (fd !== 7) begin n_bad++; $display("FAIL rstfill_miss_lat: got %0d want 7", fd); end
    m_fill(32'h700);
  endtask

  task automatic test_random();
    int fd, nd, nr, elat, en; logic [31:0] ins, pcd, pc, g, ew; bit hit;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        m_flush();
      end
      if (i % 10 == 9) pc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      else pc = 32'h1000 + 32'($urandom_range(0, 3) << 7) + 32'($urandom_range(0, 3) << 2)
                + 32'($urandom_range(0, 3));
      g    = $urandom | $urandom;
      hit  = m_is_hit(pc);
      elat = hit ? 2 : exp_miss_lat(g);
      en   = hit ? 0 : 4;
      ew   = word_at(pc);
      run_fetch(pc, pc, -1, -1, g, 1'b0, 80, 1'b1, fd, nd, ins, pcd, nr);
      n_cmp++; if (fd !== elat) begin n_bad++; $display("FAIL rand_lat[%0d] pc=%h: got %0d want %0d", i, pc, fd, elat); end
      n_cmp++; if (ins !== ew) begin n_bad++; $display("FAIL rand_inst[%0d] pc=%h: got %h want %h", i, pc, ins, ew); end
      n_cmp++; if (!addrs_ok(pc, en)) begin n_bad++; $display("FAIL rand_addrs[%0d] pc=%h: got %0d grants want %0d", i, pc, q_addr.size(), en); end
      m_fill(pc);
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_grant_gaps();
    test_flush_mid_fill();
    test_branch();
    test_rdy_stall();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
